// File: rtl/axis_pkg.sv
// axis_pkg: shared FSM state type and default parameters for the AXI-Stream packet master.
package axis_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_PKT_LEN = 8;
  localparam int DEF_FIFO_DEPTH = 4;
endpackage

// File: rtl/axis_cmd_fifo.sv
// axis_cmd_fifo: command FIFO holding packet seeds; head is visible on dout while non-empty.
module axis_cmd_fifo import axis_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign dout = mem[rp];
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/axis_pkt_master.sv
// axis_pkt_master: queues seed commands and emits PKT_LEN-beat incrementing packets on AXI-Stream.
// Define AXIS_PKT_CNT_EN to add the 32-bit pkt_count output.
module axis_pkt_master import axis_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PKT_LEN = DEF_PKT_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  output logic              cmd_full,
  output logic              drop_err,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy
`ifdef AXIS_PKT_CNT_EN
  ,
  output logic [31:0]       pkt_count
`endif
);
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);
  state_t state;
  logic [BW-1:0] beat;
  logic [DATA_W-1:0] seed, head;
  logic empty, pop, push, done;
  assign done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign pop = !empty && (state == IDLE || done);
  assign push = newd && (!cmd_full || pop);
  assign busy = state == SEND || !empty;
  axis_cmd_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .dout(head), .full(cmd_full), .empty(empty)
  );
  // The first beat of a packet is presented one cycle after entering SEND; later packets chain without a bubble.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      seed <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tdata <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= newd && cmd_full && !pop;
      if (state == IDLE) begin
        if (!empty) begin
          seed <= head;
          beat <= '0;
          state <= SEND;
        end
      end else if (!m_axis_tvalid) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata <= seed + DATA_W'(beat);
        m_axis_tlast <= beat == LAST;
      end else if (m_axis_tready) begin
        if (!m_axis_tlast) begin
          beat <= beat + 1'b1;
          m_axis_tdata <= seed + DATA_W'(beat + 1'b1);
          m_axis_tlast <= (beat + 1'b1) == LAST;
        end else if (!empty) begin
          seed <= head;
          beat <= '0;
          m_axis_tdata <= head;
          m_axis_tlast <= LAST == '0;
        end else begin
          state <= IDLE;
          m_axis_tvalid <= 1'b0;
          m_axis_tlast <= 1'b0;
          m_axis_tdata <= '0;
        end
      end
    end
`ifdef AXIS_PKT_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) pkt_count <= '0;
    else if (done) pkt_count <= pkt_count + 1'b1;
`endif
endmodule

// File: tb/tb_axis_pkt_master.sv
// tb_axis_pkt_master: directed bench with a queue-based behavioural model checked every cycle.
module tb_axis_pkt_master;
  localparam int DATA_W = 8;
  localparam int PKT_LEN = 8;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic newd = 1'b0;
  logic [7:0] din = '0;
  logic tready = 1'b0;
  logic cmd_full, drop_err, tvalid, tlast, busy;
  logic [7:0] tdata;
  logic u1_full, u1_drop, u1_tvalid, u1_tlast, u1_busy;
  logic [7:0] u1_tdata;
`ifdef AXIS_PKT_CNT_EN
  logic [31:0] pkt_count, u1_count;
`endif

  axis_pkt_master #(.DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .newd(newd), .din(din), .cmd_full(cmd_full), .drop_err(drop_err),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .busy(busy)
`ifdef AXIS_PKT_CNT_EN
    , .pkt_count(pkt_count)
`endif
  );

  axis_pkt_master #(.DATA_W(DATA_W), .PKT_LEN(1), .FIFO_DEPTH(DEPTH)) u1 (
    .clk(clk), .rst(rst), .newd(newd), .din(din), .cmd_full(u1_full), .drop_err(u1_drop),
    .m_axis_tdata(u1_tdata), .m_axis_tvalid(u1_tvalid), .m_axis_tready(tready), .m_axis_tlast(u1_tlast),
    .busy(u1_busy)
`ifdef AXIS_PKT_CNT_EN
    , .pkt_count(u1_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, got, exp, cyc);
    end
  endfunction

  // Behavioural model: seeds waiting, current packet seed/beat, whether a beat is on the bus.
  int q[$];
  bit act = 0, vld = 0, drp = 0;
  int seed_m = 0, beat_m = 0, pk = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      act = 0; vld = 0; drp = 0; seed_m = 0; beat_m = 0; pk = 0;
    end else begin
      bit popped, fullb;
      fullb = q.size() == DEPTH;
      popped = 0;
      if (vld && tready) begin
        if (beat_m == PKT_LEN - 1) begin
          pk++;
          if (q.size() > 0) begin seed_m = q.pop_front(); beat_m = 0; popped = 1; end
          else begin act = 0; vld = 0; end
        end else beat_m++;
      end else if (!act && q.size() > 0) begin
        seed_m = q.pop_front(); beat_m = 0; act = 1; popped = 1;
      end else if (act) vld = 1;
      drp = 0;
      if (newd) begin
        if (!fullb || popped) q.push_back(int'(din));
        else drp = 1;
      end
    end
  end

  logic [7:0] ld[$];
  logic ll[$];
  int lc[$];
  int first_cyc = -1, ndrop = 0;
  logic pv = 0, pr = 0, pl = 0;
  logic [7:0] pd = '0;
  always @(negedge clk) begin
    chk("tvalid", tvalid, vld);
    chk("tdata", tdata, vld ? 8'(seed_m + beat_m) : 8'h00);
    chk("tlast", tlast, vld && beat_m == PKT_LEN - 1);
    chk("cmd_full", cmd_full, q.size() == DEPTH);
    chk("busy", busy, act || q.size() > 0);
    chk("drop_err", drop_err, drp);
    chk("len1_tlast", u1_tlast, u1_tvalid);
`ifdef AXIS_PKT_CNT_EN
    chk("pkt_count", pkt_count, pk);
`endif
    if (!rst && pv && !pr) begin
      chk("hold_tvalid", tvalid, 1'b1);
      chk("hold_tdata", tdata, pd);
      chk("hold_tlast", tlast, pl);
    end
    if (tvalid && !pv && first_cyc < 0) first_cyc = cyc;
    if (tvalid && tready) begin ld.push_back(tdata); ll.push_back(tlast); lc.push_back(cyc); end
    if (drop_err) ndrop++;
    pv = tvalid && !rst; pr = tready; pd = tdata; pl = tlast;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [7:0] d, output int c);
    newd = 1'b1;
    din = d;
    tick();
    c = cyc;
    newd = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (busy && n < lim) begin tick(); n++; end
    chk("drain_in_time", n < lim, 1'b1);
    tick(); tick();
  endtask

  task automatic clr();
    ld.delete(); ll.delete(); lc.delete(); first_cyc = -1;
  endtask

  task automatic check_pkt(input string n, input int base, input int off);
    for (int i = 0; i < PKT_LEN; i++) begin
      chk({n, "_data"}, ld[off+i], 8'(base + i));
      chk({n, "_last"}, ll[off+i], i == PKT_LEN - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c0, c1, n;
    tick(); tick();
    chk("reset_tvalid", tvalid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Basic single packet at full throughput
    tready = 1'b1;
    clr();
    cmd(8'h05, c0);
    drain(40);
    chk("basic_beats", ld.size(), PKT_LEN);
    if (ld.size() == PKT_LEN) check_pkt("basic", 8'h05, 0);
    chk("basic_first_valid_delay", first_cyc - c0, 2);
    chk("basic_last_lit", ld.size() > 7 ? ld[7] : 8'hxx, 8'h0C);

    // Backpressure: ready toggles every cycle
    clr();
    newd = 1'b1; din = 8'h05; tready = 1'b0;
    tick();
    newd = 1'b0;
    for (int i = 0; i < 40; i++) begin tready = ~tready; tick(); end
    tready = 1'b1;
    drain(40);
    chk("bp_beats", ld.size(), PKT_LEN);
    if (ld.size() == PKT_LEN) check_pkt("bp", 8'h05, 0);

    // Back-to-back packets with no valid gap
    clr();
    cmd(8'h10, c0);
    cmd(8'h20, c1);
    drain(60);
    chk("b2b_beats", ld.size(), 2 * PKT_LEN);
    if (ld.size() == 2 * PKT_LEN) begin
      check_pkt("b2b0", 8'h10, 0);
      check_pkt("b2b1", 8'h20, PKT_LEN);
      for (int i = 1; i < 2 * PKT_LEN; i++) chk("b2b_no_gap", lc[i] - lc[i-1], 1);
      chk("b2b_last_lit", ld[15], 8'h27);
    end

    // Overflow while stalled, plus data wrap from 0xFE
    clr();
    ndrop = 0;
    tready = 1'b0;
    cmd(8'hFE, c0);
    tick(); tick(); tick();
    for (int i = 1; i <= 5; i++) cmd(8'(i), c1);
    tick();
    chk("ovf_full", cmd_full, 1'b1);
    chk("ovf_drops", ndrop, 1);
    tready = 1'b1;
    drain(100);
    chk("ovf_beats", ld.size(), 5 * PKT_LEN);
    if (ld.size() == 5 * PKT_LEN) begin
      chk("wrap0", ld[0], 8'hFE);
      chk("wrap1", ld[1], 8'hFF);
      chk("wrap2", ld[2], 8'h00);
      check_pkt("ovf_tail", 8'h04, 4 * PKT_LEN);
    end

    // Reset in the middle of a packet
    clr();
    cmd(8'h40, c0);
    n = 0;
    while (!(tvalid && tdata == 8'h43) && n < 30) begin tick(); n++; end
    chk("rst_reach_beat3", n < 30, 1'b1);
    rst = 1'b1;
    #3;
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tdata", tdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    tick(); tick();
    rst = 1'b0;
    clr();
    repeat (10) tick();
    chk("rst_no_beats", ld.size(), 0);
    cmd(8'h50, c0);
    drain(40);
    chk("rst_resume_beats", ld.size(), PKT_LEN);
    if (ld.size() == PKT_LEN) check_pkt("rst_resume", 8'h50, 0);
    cmd(8'h60, c0);
    cmd(8'h70, c1);
    drain(60);
`ifdef AXIS_PKT_CNT_EN
    chk("pkt_count_three", pkt_count, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
